// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + pending-write scoreboard for the 32x32 register file.
// Latency: transfer at edge N -> regWrite/write_reg/write_data valid N..N+1; pending clears at N+1.
// Backpressure: readies are combinational; mem has priority until the ALU is refused STARVE_MAX times in a row.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_reg,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_reg,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic                   regWrite,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   starved
);

  typedef enum logic {NORMAL = 1'b0, FORCE_ALU = 1'b1} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                reg_write_q, reg_write_d;
  logic [2**ADDR_W-1:0] pending_q, pending_d;
  logic                alu_xfer, mem_xfer;

  assign alu_xfer = alu_valid && alu_ready;
  assign mem_xfer = mem_valid && mem_ready;

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  // Next state: the counter's next value drives the switch so the force grant
  // is in effect in the same cycle the counter sits at its limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:    if (cnt_d == STARVE_LIM) state_d = FORCE_ALU;
      FORCE_ALU: if (alu_xfer)            state_d = NORMAL;
      default:   state_d = NORMAL;
    endcase
  end

  // Grant outputs: mem first in NORMAL, ALU only in FORCE_ALU
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    starved   = (state_q == FORCE_ALU);
    if (state_q == FORCE_ALU) begin
      alu_ready = alu_valid;
    end else if (mem_valid) begin
      mem_ready = 1'b1;
    end else begin
      alu_ready = alu_valid;
    end
  end

  // Starvation count: grows while the ALU is refused, saturates, clears otherwise
  always_comb begin
    cnt_d = 4'd0;
    if (alu_valid && !alu_ready)
      cnt_d = (cnt_q == STARVE_LIM) ? cnt_q : cnt_q + 4'd1;
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  // Write-stage next values: register 0 transfers complete but never write
  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    if (mem_xfer) begin
      write_reg_d  = mem_reg;
      write_data_d = mem_data;
      reg_write_d  = (mem_reg != '0);
    end else if (alu_xfer) begin
      write_reg_d  = alu_reg;
      write_data_d = alu_data;
      reg_write_d  = (alu_reg != '0);
    end
  end

  // Write-stage registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Scoreboard next value: commit clears, issue sets (set wins), r0 never pending
  always_comb begin
    pending_d = pending_q;
    if (reg_write_q)
      pending_d[write_reg_q] = 1'b0;
    if (issue_valid && (issue_reg != '0))
      pending_d[issue_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign regWrite   = reg_write_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: each record is one clock cycle.
// Inputs are driven just after the falling edge; outputs are compared 1ns later.
// Expected values are hand-derived cycle by cycle from the block's behaviour.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_reg = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regWrite;
  logic [31:0] pending;
  logic        starved;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
    .pending(pending), .starved(starved)
  );

  typedef struct {
    logic        rst;
    logic        av;  logic [4:0] ar; logic [31:0] ad;
    logic        mv;  logic [4:0] mr; logic [31:0] md;
    logic        iv;  logic [4:0] ir;
    logic        e_ar, e_mr, e_st, e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  function automatic vec_t mk(
    input logic rst,
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic iv, input logic [4:0] ir,
    input logic e_ar, input logic e_mr, input logic e_st, input logic e_rw,
    input logic [4:0] e_wr, input logic [31:0] e_wd, input logic [31:0] e_pend);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md; v.iv = iv; v.ir = ir;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_st = e_st; v.e_rw = e_rw;
    v.e_wr = e_wr; v.e_wd = e_wd; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and compare every output against the record
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    reset       = v.rst;
    alu_valid   = v.av; alu_reg = v.ar; alu_data = v.ad;
    mem_valid   = v.mv; mem_reg = v.mr; mem_data = v.md;
    issue_valid = v.iv; issue_reg = v.ir;
    #1;
    chk({tag, ".alu_ready"},  {31'd0, alu_ready}, {31'd0, v.e_ar});
    chk({tag, ".mem_ready"},  {31'd0, mem_ready}, {31'd0, v.e_mr});
    chk({tag, ".starved"},    {31'd0, starved},   {31'd0, v.e_st});
    chk({tag, ".regWrite"},   {31'd0, regWrite},  {31'd0, v.e_rw});
    chk({tag, ".write_reg"},  {27'd0, write_reg}, {27'd0, v.e_wr});
    chk({tag, ".write_data"}, write_data,         v.e_wd);
    chk({tag, ".pending"},    pending,            v.e_pend);
  endtask

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    //            rst av ar  ad            mv mr md     iv ir   ar mr st rw wr  wd            pend
    tbl[0]  = mk(1, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 0, 0, 0,            0);        // reset state
    tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,   1, 0, 0, 0, 0, 0,            0);        // ALU only
    tbl[2]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 0, 5, 32'hDEADBEEF, 0);        // hold, no write
    tbl[4]  = mk(0, 1, 4, 32'h22,       1, 3, 32'h11, 0, 0,  0, 1, 0, 0, 5, 32'hDEADBEEF, 0);        // both: mem wins
    tbl[5]  = mk(0, 1, 4, 32'h22,       0, 0, 0,     0, 0,   1, 0, 0, 1, 3, 32'h11,       0);        // alu next
    tbl[6]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 1, 4, 32'h22,       0);
    tbl[7]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 0, 4, 32'h22,       0);
    tbl[8]  = mk(0, 1, 0, 32'hFFFF,     0, 0, 0,     1, 7,   1, 0, 0, 0, 4, 32'h22,       0);        // r0 write, issue r7
    tbl[9]  = mk(0, 0, 0, 0,            0, 0, 0,     1, 0,   0, 0, 0, 0, 0, 32'hFFFF,     32'h80);   // r0: no regWrite; issue r0
    tbl[10] = mk(0, 0, 0, 0,            1, 7, 32'h77, 0, 0,  0, 1, 0, 0, 0, 32'hFFFF,     32'h80);   // load to r7
    tbl[11] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 1, 7, 32'h77,       32'h80);   // commit cycle
    tbl[12] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 0, 7, 32'h77,       0);        // cleared
    tbl[13] = mk(0, 0, 0, 0,            1, 7, 32'h78, 1, 7,  0, 1, 0, 0, 7, 32'h77,       0);        // issue r7 + load r7
    tbl[14] = mk(0, 0, 0, 0,            0, 0, 0,     1, 7,   0, 0, 0, 1, 7, 32'h78,       32'h80);   // commit + re-issue
    tbl[15] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0,   0, 0, 0, 0, 7, 32'h78,       32'h80);   // set wins

    for (int i = 0; i < NV; i++)
      run_vec(tbl[i], $sformatf("v%0d", i));

    // Starvation: mem and ALU held valid; ALU forced on the 4th cycle
    run_vec(mk(0, 1, 10, 32'hA0, 1, 9, 32'h90, 0, 0,  0, 1, 0, 0, 7, 32'h78, 32'h80), "starve0");
    run_vec(mk(0, 1, 10, 32'hA0, 1, 9, 32'h90, 0, 0,  0, 1, 0, 1, 9, 32'h90, 32'h80), "starve1");
    run_vec(mk(0, 1, 10, 32'hA0, 1, 9, 32'h90, 0, 0,  0, 1, 0, 1, 9, 32'h90, 32'h80), "starve2");
    run_vec(mk(0, 1, 10, 32'hA0, 1, 9, 32'h90, 0, 0,  1, 0, 1, 1, 9, 32'h90, 32'h80), "starve3");
    run_vec(mk(0, 0, 0,  0,      1, 9, 32'h90, 0, 0,  0, 1, 0, 1, 10, 32'hA0, 32'h80), "starve_back");

    // Reset mid-flight: mem transfer, then reset the next edge; counter must restart from 0
    run_vec(mk(0, 1, 12, 32'hC0, 1, 2, 32'h20, 0, 0,  0, 1, 0, 1, 9, 32'h90, 32'h80), "rst0");
    run_vec(mk(1, 1, 12, 32'hC0, 1, 2, 32'h20, 1, 13, 0, 1, 0, 1, 2, 32'h20, 32'h80), "rst1");
    run_vec(mk(0, 1, 12, 32'hC0, 1, 2, 32'h20, 0, 0,  0, 1, 0, 0, 0, 32'h0,  32'h0),  "rst2");
    run_vec(mk(0, 1, 12, 32'hC0, 1, 2, 32'h20, 0, 0,  0, 1, 0, 1, 2, 32'h20, 32'h0),  "rst3");
    run_vec(mk(0, 1, 12, 32'hC0, 1, 2, 32'h20, 0, 0,  0, 1, 0, 1, 2, 32'h20, 32'h0),  "rst4");
    run_vec(mk(0, 1, 12, 32'hC0, 1, 2, 32'h20, 0, 0,  1, 0, 1, 1, 2, 32'h20, 32'h0),  "rst5");
    run_vec(mk(0, 0, 0,  0,      0, 0, 0,      0, 0,  0, 0, 0, 1, 12, 32'hC0, 32'h0), "rst6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
